// File: rtl/multicore_shared_ram_if.sv
// multicore_shared_ram_if: one Avalon-MM port of the shared RAM (rev 1.0).
`default_nettype none

interface multicore_shared_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/multicore_shared_ram.sv
// multicore_shared_ram: single-port RAM shared by two Avalon-MM slaves behind a
// round-robin arbiter, with pipelined reads and clken/reset_req freeze (rev 1.0).
`default_nettype none

module multicore_shared_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  reset_req,
  multicore_shared_ram_if.slave s1,
  multicore_shared_ram_if.slave s2
);
  localparam int   NUM_LANES = DATA_WIDTH / 8;
  localparam int   DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic PORT_S1   = 1'b0;
  localparam logic PORT_S2   = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                    last_grant_q;
  logic                    last_grant_d;
  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [READ_LATENCY-1:0] pipe_valid_d;
  logic [READ_LATENCY-1:0] pipe_tag_q;
  logic [READ_LATENCY-1:0] pipe_tag_d;
  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_data_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   s1_rdata_q;
  logic [DATA_WIDTH-1:0]   s1_rdata_d;
  logic [DATA_WIDTH-1:0]   s2_rdata_q;
  logic [DATA_WIDTH-1:0]   s2_rdata_d;

  logic                  stall;
  logic                  req1;
  logic                  req2;
  logic                  grant1;
  logic                  grant2;
  logic                  any_grant;
  logic                  grant_tag;
  logic                  acc_wr;
  logic                  acc_rd;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [NUM_LANES-1:0]  acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  head_valid;
  logic                  head_tag;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  present1;
  logic                  present2;

  // Grants are gated by reset_n so waitrequest stays high while in reset.
  always_comb begin
    stall     = ~clken | reset_req;
    req1      = s1.read | s1.write;
    req2      = s2.read | s2.write;
    grant1    = reset_n & ~stall & req1 & (~req2 | (last_grant_q == PORT_S2));
    grant2    = reset_n & ~stall & req2 & (~req1 | (last_grant_q == PORT_S1));
    any_grant = grant1 | grant2;
    grant_tag = grant2 ? PORT_S2 : PORT_S1;
    acc_addr  = grant2 ? s2.address    : s1.address;
    acc_be    = grant2 ? s2.byteenable : s1.byteenable;
    acc_wdata = grant2 ? s2.writedata  : s1.writedata;
    acc_wr    = any_grant & (grant2 ? s2.write : s1.write);
    acc_rd    = any_grant & ~acc_wr;
    last_grant_d = any_grant ? grant_tag : last_grant_q;
  end

  assign s1.waitrequest = ~grant1;
  assign s2.waitrequest = ~grant2;

  // The whole read pipeline freezes on stall so a delivery slot survives it.
  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_tag_d   = pipe_tag_q;
    pipe_data_d  = pipe_data_q;
    if (!stall) begin
      pipe_valid_d[0] = acc_rd;
      pipe_tag_d[0]   = grant_tag;
      if (acc_rd) begin
        pipe_data_d[0] = mem_q[acc_addr];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_d[i] = pipe_valid_q[i-1];
        pipe_tag_d[i]   = pipe_tag_q[i-1];
        pipe_data_d[i]  = pipe_data_q[i-1];
      end
    end
  end

  always_comb begin
    head_valid = pipe_valid_q[READ_LATENCY-1] & ~stall;
    head_tag   = pipe_tag_q[READ_LATENCY-1];
    head_data  = pipe_data_q[READ_LATENCY-1];
    present1   = head_valid & (head_tag == PORT_S1);
    present2   = head_valid & (head_tag == PORT_S2);
    s1_rdata_d = present1 ? head_data : s1_rdata_q;
    s2_rdata_d = present2 ? head_data : s2_rdata_q;
  end

  assign s1.readdata      = s1_rdata_d;
  assign s2.readdata      = s2_rdata_d;
  assign s1.readdatavalid = present1;
  assign s2.readdatavalid = present2;

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (acc_be[l]) begin
          mem_q[acc_addr][l*8 +: 8] <= acc_wdata[l*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= PORT_S2;
      pipe_valid_q <= '0;
      pipe_tag_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
      s1_rdata_q   <= '0;
      s2_rdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_tag_q   <= pipe_tag_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= pipe_data_d[i];
      end
      s1_rdata_q   <= s1_rdata_d;
      s2_rdata_q   <= s2_rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicore_shared_ram.sv
// tb_multicore_shared_ram: directed bench; latency-1 and latency-2 instances see identical stimulus.
`default_nettype none

module tb_multicore_shared_ram;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clken = 1'b1;
  logic reset_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicore_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p1a ();
  multicore_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p2a ();
  multicore_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p1b ();
  multicore_shared_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p2b ();

  multicore_shared_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(p1a), .s2(p2a)
  );
  multicore_shared_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_l2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(p1b), .s2(p2b)
  );

  typedef struct {
    logic rd1; logic wr1; logic [AW-1:0] ad1; logic [3:0] be1; logic [DW-1:0] wd1;
    logic rd2; logic wr2; logic [AW-1:0] ad2; logic [3:0] be2; logic [DW-1:0] wd2;
    logic ew1; logic ew2; logic ev1; logic ev2;
    logic cd1; logic [DW-1:0] ed1; logic cd2; logic [DW-1:0] ed2;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(
    input logic rd1, input logic wr1, input logic [AW-1:0] ad1, input logic [3:0] be1, input logic [DW-1:0] wd1,
    input logic rd2, input logic wr2, input logic [AW-1:0] ad2, input logic [3:0] be2, input logic [DW-1:0] wd2,
    input logic ew1, input logic ew2, input logic ev1, input logic ev2,
    input logic cd1, input logic [DW-1:0] ed1, input logic cd2, input logic [DW-1:0] ed2);
    vec_t v;
    v.rd1 = rd1; v.wr1 = wr1; v.ad1 = ad1; v.be1 = be1; v.wd1 = wd1;
    v.rd2 = rd2; v.wr2 = wr2; v.ad2 = ad2; v.be2 = be2; v.wd2 = wd2;
    v.ew1 = ew1; v.ew2 = ew2; v.ev1 = ev1; v.ev2 = ev2;
    v.cd1 = cd1; v.ed1 = ed1; v.cd2 = cd2; v.ed2 = ed2;
    return v;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(
    input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [3:0] e1, input logic [DW-1:0] d1,
    input logic r2, input logic w2, input logic [AW-1:0] a2, input logic [3:0] e2, input logic [DW-1:0] d2);
    p1a.read = r1; p1a.write = w1; p1a.address = a1; p1a.byteenable = e1; p1a.writedata = d1;
    p1b.read = r1; p1b.write = w1; p1b.address = a1; p1b.byteenable = e1; p1b.writedata = d1;
    p2a.read = r2; p2a.write = w2; p2a.address = a2; p2a.byteenable = e2; p2a.writedata = d2;
    p2b.read = r2; p2b.write = w2; p2b.address = a2; p2b.byteenable = e2; p2b.writedata = d2;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic set_stall(input logic s, input bit via_req);
    if (via_req) begin
      clken = 1'b1;
      reset_req = s;
    end else begin
      clken = ~s;
      reset_req = 1'b0;
    end
  endtask

  task automatic stall_run(input bit via_req);
    @(negedge clk);
    drv(1'b1, 1'b0, 10'h005, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
    set_stall(1'b0, via_req);
    #1 chk_bit("stl_accept_wait", p1b.waitrequest, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk_bit("stl_l1_rdv", p1a.readdatavalid, 1'b1);
    chk_word("stl_l1_data", p1a.readdata, 32'hDEADBEEF);
    chk_bit("stl_l2_not_early", p1b.readdatavalid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(1'b1, 1'b0, 10'h3FF, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
      set_stall(1'b1, via_req);
      #1;
      chk_bit("stl_hold_rdv", p1b.readdatavalid, 1'b0);
      chk_bit("stl_hold_wait_l2", p1b.waitrequest, 1'b1);
      chk_bit("stl_hold_wait_l1", p1a.waitrequest, 1'b1);
    end
    @(negedge clk);
    set_stall(1'b0, via_req);
    #1;
    chk_bit("stl_resume_rdv", p1b.readdatavalid, 1'b1);
    chk_word("stl_resume_data", p1b.readdata, 32'hDEADBEEF);
    chk_bit("stl_resume_wait", p1b.waitrequest, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk_bit("stl_gap_rdv_l2", p1b.readdatavalid, 1'b0);
    chk_bit("stl_next_rdv_l1", p1a.readdatavalid, 1'b1);
    chk_word("stl_next_data_l1", p1a.readdata, 32'h11BB33DD);
    @(negedge clk);
    #1;
    chk_bit("stl_next_rdv_l2", p1b.readdatavalid, 1'b1);
    chk_word("stl_next_data_l2", p1b.readdata, 32'h11BB33DD);
  endtask

  initial begin
    tbl[0]  = mk(1,0,10'h005,4'hF,32'hDEADBEEF, 0,0,10'h000,4'h0,32'h0, 0,1,0,0, 0,32'h0,        1,32'h0);
    tbl[1]  = mk(1,0,10'h005,4'hF,32'h0,        0,0,10'h000,4'h0,32'h0, 0,1,0,0, 0,32'h0,        1,32'h0);
    tbl[0].rd1 = 1'b0; tbl[0].wr1 = 1'b1;
    tbl[2]  = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0, 1,1,1,0, 1,32'hDEADBEEF, 1,32'h0);
    tbl[3]  = mk(0,1,10'h3FF,4'hF,32'h11223344, 0,0,10'h000,4'h0,32'h0, 0,1,0,0, 1,32'hDEADBEEF, 1,32'h0);
    tbl[4]  = mk(0,0,10'h000,4'h0,32'h0,        0,1,10'h3FF,4'h5,32'hAABBCCDD, 1,0,0,0, 1,32'hDEADBEEF, 1,32'h0);
    tbl[5]  = mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h3FF,4'hF,32'h0, 1,0,0,0, 1,32'hDEADBEEF, 1,32'h0);
    tbl[6]  = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0, 1,1,0,1, 1,32'hDEADBEEF, 1,32'h11BB33DD);
    tbl[7]  = mk(0,1,10'h001,4'hF,32'h01010101, 0,0,10'h000,4'h0,32'h0, 0,1,0,0, 1,32'hDEADBEEF, 1,32'h11BB33DD);
    tbl[8]  = mk(0,0,10'h000,4'h0,32'h0,        0,1,10'h002,4'hF,32'h02020202, 1,0,0,0, 1,32'hDEADBEEF, 1,32'h11BB33DD);
    tbl[9]  = mk(1,0,10'h001,4'hF,32'h0,        1,0,10'h002,4'hF,32'h0, 0,1,0,0, 1,32'hDEADBEEF, 1,32'h11BB33DD);
    tbl[10] = mk(1,0,10'h001,4'hF,32'h0,        1,0,10'h002,4'hF,32'h0, 1,0,1,0, 1,32'h01010101, 1,32'h11BB33DD);
    tbl[11] = mk(1,0,10'h001,4'hF,32'h0,        1,0,10'h002,4'hF,32'h0, 0,1,0,1, 1,32'h01010101, 1,32'h02020202);
    tbl[12] = mk(1,0,10'h001,4'hF,32'h0,        1,0,10'h002,4'hF,32'h0, 1,0,1,0, 1,32'h01010101, 1,32'h02020202);
    tbl[13] = mk(1,0,10'h001,4'hF,32'h0,        1,0,10'h002,4'hF,32'h0, 0,1,0,1, 1,32'h01010101, 1,32'h02020202);
    tbl[14] = mk(1,0,10'h001,4'hF,32'h0,        1,0,10'h002,4'hF,32'h0, 1,0,1,0, 1,32'h01010101, 1,32'h02020202);
    tbl[15] = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0, 1,1,0,1, 1,32'h01010101, 1,32'h02020202);
    tbl[16] = mk(1,1,10'h001,4'hF,32'hCAFEF00D, 0,0,10'h000,4'h0,32'h0, 0,1,0,0, 1,32'h01010101, 1,32'h02020202);
    tbl[17] = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0, 1,1,0,0, 1,32'h01010101, 1,32'h02020202);
    tbl[18] = mk(1,0,10'h001,4'hF,32'h0,        0,0,10'h000,4'h0,32'h0, 0,1,0,0, 1,32'h01010101, 1,32'h02020202);
    tbl[19] = mk(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0, 1,1,1,0, 1,32'hCAFEF00D, 1,32'h02020202);

    // Reset held for 3 cycles with s1 requesting a read.
    drv(1'b1, 1'b0, 10'h000, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
    #1 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_bit("rst_wait1", p1a.waitrequest, 1'b1);
      chk_bit("rst_wait2", p2a.waitrequest, 1'b1);
      chk_bit("rst_rdv1", p1a.readdatavalid, 1'b0);
      chk_bit("rst_rdv2", p2a.readdatavalid, 1'b0);
      chk_word("rst_rdata1", p1a.readdata, '0);
      chk_word("rst_rdata2", p2a.readdata, '0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_bit("rel_grant1", p1a.waitrequest, 1'b0);
    chk_bit("rel_wait2", p2a.waitrequest, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk_bit("rel_rdv1", p1a.readdatavalid, 1'b1);
    chk_bit("rel_rdv2", p2a.readdatavalid, 1'b0);

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drv(tbl[k].rd1, tbl[k].wr1, tbl[k].ad1, tbl[k].be1, tbl[k].wd1,
          tbl[k].rd2, tbl[k].wr2, tbl[k].ad2, tbl[k].be2, tbl[k].wd2);
      #1;
      chk_bit($sformatf("t%0d_wait1", k), p1a.waitrequest, tbl[k].ew1);
      chk_bit($sformatf("t%0d_wait2", k), p2a.waitrequest, tbl[k].ew2);
      chk_bit($sformatf("t%0d_rdv1", k), p1a.readdatavalid, tbl[k].ev1);
      chk_bit($sformatf("t%0d_rdv2", k), p2a.readdatavalid, tbl[k].ev2);
      if (tbl[k].cd1) chk_word($sformatf("t%0d_rdata1", k), p1a.readdata, tbl[k].ed1);
      if (tbl[k].cd2) chk_word($sformatf("t%0d_rdata2", k), p2a.readdata, tbl[k].ed2);
    end

    // Drain the latency-2 instance before the stall sequences.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle();
    end
    stall_run(1'b0);
    stall_run(1'b1);

    // Reset one cycle after a read is accepted drops it.
    @(negedge clk);
    drv(1'b1, 1'b0, 10'h001, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
    #1 chk_bit("mrst_accept", p1a.waitrequest, 1'b0);
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    #1;
    chk_bit("mrst_rdv_l1", p1a.readdatavalid, 1'b0);
    chk_bit("mrst_rdv_l2", p1b.readdatavalid, 1'b0);
    chk_word("mrst_rdata_l1", p1a.readdata, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) reset_n = 1'b1;
      #1;
      chk_bit("mrst_after_l1", p1a.readdatavalid, 1'b0);
      chk_bit("mrst_after_l2", p1b.readdatavalid, 1'b0);
    end
    @(negedge clk);
    drv(1'b1, 1'b0, 10'h005, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    drv(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 10'h3FF, 4'hF, '0);
    #1;
    chk_bit("keep_rdv_005", p1a.readdatavalid, 1'b1);
    chk_word("keep_data_005", p1a.readdata, 32'hDEADBEEF);
    @(negedge clk);
    drv(1'b1, 1'b0, 10'h001, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk_bit("keep_rdv_3ff", p2a.readdatavalid, 1'b1);
    chk_word("keep_data_3ff", p2a.readdata, 32'h11BB33DD);
    @(negedge clk);
    idle();
    #1;
    chk_bit("keep_rdv_001", p1a.readdatavalid, 1'b1);
    chk_word("keep_data_001", p1a.readdata, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
